// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg
// Shared constants for the memory stage: memlen encodings, FSM state
// encoding, byte-enable constants and small lane helpers.
package mem_access_stage_pkg;

   localparam logic [1:0] LEN_BYTE = 2'b00;
   localparam logic [1:0] LEN_HALF = 2'b01;
   localparam logic [1:0] LEN_WORD = 2'b10;
   localparam logic [1:0] LEN_RSVD = 2'b11;   // decoded as word

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   localparam logic [3:0] BE_HALF_LO = 4'b0011;
   localparam logic [3:0] BE_HALF_HI = 4'b1100;
   localparam logic [3:0] BE_WORD    = 4'b1111;

   function automatic logic [3:0] byte_en(input logic [1:0] len, input logic [1:0] off);
      case (len)
         LEN_BYTE: byte_en = 4'b0001 << off;
         LEN_HALF: byte_en = off[1] ? BE_HALF_HI : BE_HALF_LO;
         default:  byte_en = BE_WORD;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [1:0] len, input logic [31:0] data);
      case (len)
         LEN_BYTE: store_lanes = {4{data[7:0]}};
         LEN_HALF: store_lanes = {2{data[15:0]}};
         default:  store_lanes = data;
      endcase
   endfunction

   function automatic logic misaligned(input logic [1:0] len, input logic [1:0] off);
      case (len)
         LEN_BYTE: misaligned = 1'b0;
         LEN_HALF: misaligned = off[0];
         default:  misaligned = |off;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
// Data-memory request/ack bus.
//   master (stage):  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o out; dm_ack_i, dm_rdata_i in
//   slave  (memory): the reverse
interface mem_access_stage_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              dm_req_o;
   logic              dm_we_o;
   logic [ADDR_W-1:0] dm_addr_o;
   logic [3:0]        dm_be_o;
   logic [DATA_W-1:0] dm_wdata_o;
   logic              dm_ack_i;
   logic [DATA_W-1:0] dm_rdata_i;

   modport master (
      output dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
      input  dm_ack_i, dm_rdata_i
   );

   modport slave (
      input  dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o,
      output dm_ack_i, dm_rdata_i
   );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// mem_access_stage_load_align
// Combinational load-data alignment: picks the byte/half lane addressed by
// off_i out of a 32-bit memory word and sign- or zero-extends it.
//   rdata_i  memory word        off_i  addr[1:0]
//   len_i    memlen encoding    sext_i 1 = sign extend
//   data_o   aligned, extended load value
module mem_access_stage_load_align
   import mem_access_stage_pkg::*;
(
   input  logic [31:0] rdata_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  len_i,
   input  logic        sext_i,
   output logic [31:0] data_o
);
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      case (len_i)
         LEN_BYTE: data_o = {{24{sext_i & byte_sel[7]}}, byte_sel};
         LEN_HALF: data_o = {{16{sext_i & half_sel[15]}}, half_sel};
         default:  data_o = rdata_i;
      endcase
   end
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// Pipeline memory stage: accepts the execute bundle, runs at most one
// load/store over the dm req/ack bus, and registers the write-back bundle.
//   clk, rst (async, active low)
//   valid_i/ready_o + execute bundle in (aluout_i, rd2_i, memre_i, memwe_i,
//     memlen_i, memsext_i, regwe_i, wa_i)
//   dm          data-memory bus (master modport)
//   valid_o, regwe_o, wa_o, wd_o   write-back bundle (valid_o pulses once)
//   fwd_we_o, fwd_wa_o, fwd_busy_o hazard/forwarding view of the stage
//   exc_o       misaligned-access flag
// Build option: MEM_MISALIGN_EXC_EN turns misaligned half/word accesses into
// an exception instead of a silently aligned access.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a new bundle; ALU ops retire straight to output
// WAIT    | load/store request on the bus, stall upstream until ack
module mem_access_stage
   import mem_access_stage_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] aluout_i,
   input  logic [DATA_W-1:0] rd2_i,
   input  logic              memre_i,
   input  logic              memwe_i,
   input  logic [1:0]        memlen_i,
   input  logic              memsext_i,
   input  logic              regwe_i,
   input  logic [4:0]        wa_i,
   mem_access_stage_if.master dm,
   output logic              valid_o,
   output logic              regwe_o,
   output logic [4:0]        wa_o,
   output logic [DATA_W-1:0] wd_o,
   output logic              fwd_we_o,
   output logic [4:0]        fwd_wa_o,
   output logic              fwd_busy_o,
   output logic              exc_o
);
   state_t            state_q, state_d;
   logic [DATA_W-1:0] cap_alu_q, cap_alu_d;
   logic [DATA_W-1:0] cap_wdata_q, cap_wdata_d;
   logic [3:0]        cap_be_q, cap_be_d;
   logic              cap_store_q, cap_store_d;
   logic [1:0]        cap_len_q, cap_len_d;
   logic              cap_sext_q, cap_sext_d;
   logic              cap_regwe_q, cap_regwe_d;
   logic [4:0]        cap_wa_q, cap_wa_d;
   logic              valid_q, valid_d;
   logic              regwe_q, regwe_d;
   logic [4:0]        wa_q, wa_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [DATA_W-1:0] load_data;
   logic              mem_op;
   logic              bad_align;
`ifdef MEM_MISALIGN_EXC_EN
   logic              exc_q, exc_d;
`endif

   assign mem_op = memre_i | memwe_i;

`ifdef MEM_MISALIGN_EXC_EN
   assign bad_align = misaligned(memlen_i, aluout_i[1:0]);
`else
   assign bad_align = 1'b0;
`endif

   mem_access_stage_load_align u_load_align (
      .rdata_i (dm.dm_rdata_i),
      .off_i   (cap_alu_q[1:0]),
      .len_i   (cap_len_q),
      .sext_i  (cap_sext_q),
      .data_o  (load_data)
   );

   always_comb begin
      state_d     = state_q;
      cap_alu_d   = cap_alu_q;
      cap_wdata_d = cap_wdata_q;
      cap_be_d    = cap_be_q;
      cap_store_d = cap_store_q;
      cap_len_d   = cap_len_q;
      cap_sext_d  = cap_sext_q;
      cap_regwe_d = cap_regwe_q;
      cap_wa_d    = cap_wa_q;
      valid_d     = 1'b0;
      regwe_d     = regwe_q;
      wa_d        = wa_q;
      wd_d        = wd_q;
`ifdef MEM_MISALIGN_EXC_EN
      exc_d       = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               if (!mem_op || bad_align) begin
                  // ALU op, or a rejected misaligned access that never
                  // reaches the bus and must not write a register.
                  valid_d = 1'b1;
                  regwe_d = regwe_i & ~mem_op;
                  wa_d    = wa_i;
                  wd_d    = aluout_i;
`ifdef MEM_MISALIGN_EXC_EN
                  exc_d   = mem_op;
`endif
               end else begin
                  // memwe wins when both controls are set.
                  cap_alu_d   = aluout_i;
                  cap_wdata_d = store_lanes(memlen_i, rd2_i);
                  cap_be_d    = byte_en(memlen_i, aluout_i[1:0]);
                  cap_store_d = memwe_i;
                  cap_len_d   = memlen_i;
                  cap_sext_d  = memsext_i;
                  cap_regwe_d = regwe_i;
                  cap_wa_d    = wa_i;
                  state_d     = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (dm.dm_ack_i) begin
               valid_d = 1'b1;
               regwe_d = cap_regwe_q & ~cap_store_q;
               wa_d    = cap_wa_q;
               wd_d    = cap_store_q ? cap_alu_q : load_data;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         cap_alu_q   <= '0;
         cap_wdata_q <= '0;
         cap_be_q    <= '0;
         cap_store_q <= 1'b0;
         cap_len_q   <= '0;
         cap_sext_q  <= 1'b0;
         cap_regwe_q <= 1'b0;
         cap_wa_q    <= '0;
         valid_q     <= 1'b0;
         regwe_q     <= 1'b0;
         wa_q        <= '0;
         wd_q        <= '0;
`ifdef MEM_MISALIGN_EXC_EN
         exc_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cap_alu_q   <= cap_alu_d;
         cap_wdata_q <= cap_wdata_d;
         cap_be_q    <= cap_be_d;
         cap_store_q <= cap_store_d;
         cap_len_q   <= cap_len_d;
         cap_sext_q  <= cap_sext_d;
         cap_regwe_q <= cap_regwe_d;
         cap_wa_q    <= cap_wa_d;
         valid_q     <= valid_d;
         regwe_q     <= regwe_d;
         wa_q        <= wa_d;
         wd_q        <= wd_d;
`ifdef MEM_MISALIGN_EXC_EN
         exc_q       <= exc_d;
`endif
      end
   end

   assign ready_o       = (state_q == ST_IDLE);
   assign dm.dm_req_o   = (state_q == ST_WAIT);
   assign dm.dm_we_o    = (state_q == ST_WAIT) & cap_store_q;
   assign dm.dm_addr_o  = {cap_alu_q[ADDR_W-1:2], 2'b00};
   assign dm.dm_be_o    = cap_be_q;
   assign dm.dm_wdata_o = cap_wdata_q;

   assign valid_o = valid_q;
   assign regwe_o = regwe_q;
   assign wa_o    = wa_q;
   assign wd_o    = wd_q;

   // In WAIT the hazard view is the captured instruction; otherwise it is the
   // bundle currently presented to writeback.
   assign fwd_we_o   = (state_q == ST_WAIT) ? (cap_regwe_q & ~cap_store_q) : (valid_q & regwe_q);
   assign fwd_wa_o   = (state_q == ST_WAIT) ? cap_wa_q : wa_q;
   assign fwd_busy_o = (state_q == ST_WAIT) & ~cap_store_q;

`ifdef MEM_MISALIGN_EXC_EN
   assign exc_o = exc_q;
`else
   assign exc_o = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_i = 1'b0;
   logic        ready_o;
   logic [31:0] aluout_i = '0;
   logic [31:0] rd2_i = '0;
   logic        memre_i = 1'b0;
   logic        memwe_i = 1'b0;
   logic [1:0]  memlen_i = '0;
   logic        memsext_i = 1'b0;
   logic        regwe_i = 1'b0;
   logic [4:0]  wa_i = '0;
   logic        valid_o, regwe_o, fwd_we_o, fwd_busy_o, exc_o;
   logic [4:0]  wa_o, fwd_wa_o;
   logic [31:0] wd_o;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_access_stage_if dm ();

   mem_access_stage dut (
      .clk(clk), .rst(rst_n), .valid_i(valid_i), .ready_o(ready_o),
      .aluout_i(aluout_i), .rd2_i(rd2_i), .memre_i(memre_i), .memwe_i(memwe_i),
      .memlen_i(memlen_i), .memsext_i(memsext_i), .regwe_i(regwe_i), .wa_i(wa_i),
      .dm(dm.master),
      .valid_o(valid_o), .regwe_o(regwe_o), .wa_o(wa_o), .wd_o(wd_o),
      .fwd_we_o(fwd_we_o), .fwd_wa_o(fwd_wa_o), .fwd_busy_o(fwd_busy_o), .exc_o(exc_o)
   );

   typedef struct {
      bit        re, we;
      bit [1:0]  len;
      bit        sext, regwe;
      bit [4:0]  wa;
      bit [31:0] alu, rd2, rdata;
      int        waits;
      bit        e_mem, e_exc, e_regwe;
      bit [31:0] e_wd, e_addr, e_wdata;
      bit [3:0]  e_be;
   } txn_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic txn_t mk(input bit re, input bit we, input bit [1:0] len, input bit sext,
                               input bit regwe, input bit [4:0] wa, input bit [31:0] alu,
                               input bit [31:0] rd2, input bit [31:0] rdata, input int waits,
                               input bit e_mem, input bit e_regwe, input bit [31:0] e_wd,
                               input bit [31:0] e_addr, input bit [3:0] e_be, input bit [31:0] e_wdata);
      txn_t t;
      t.re = re; t.we = we; t.len = len; t.sext = sext; t.regwe = regwe; t.wa = wa;
      t.alu = alu; t.rd2 = rd2; t.rdata = rdata; t.waits = waits;
      t.e_mem = e_mem; t.e_exc = 1'b0; t.e_regwe = e_regwe; t.e_wd = e_wd;
      t.e_addr = e_addr; t.e_be = e_be; t.e_wdata = e_wdata;
      return t;
   endfunction

   // Reference: derives expectations from the access size and byte offset arithmetically.
   function automatic txn_t model(input txn_t t);
      txn_t r;
      int off, size, lane;
      bit [31:0] mask, val;
      bit misal;
      r = t;
      r.e_exc = 1'b0; r.e_addr = '0; r.e_be = '0; r.e_wdata = '0; r.e_mem = 1'b0;
      off  = int'(t.alu % 4);
      size = (t.len == 2'd0) ? 1 : (t.len == 2'd1) ? 2 : 4;
      lane = (size == 1) ? off : (size == 2) ? (off / 2) * 2 : 0;
`ifdef MEM_MISALIGN_EXC_EN
      misal = (size == 2 && off % 2 != 0) || (size == 4 && off != 0);
`else
      misal = 1'b0;
`endif
      if (!(t.re || t.we)) begin
         r.e_regwe = t.regwe; r.e_wd = t.alu;
      end else if (misal) begin
         r.e_exc = 1'b1; r.e_regwe = 1'b0; r.e_wd = t.alu;
      end else begin
         r.e_mem  = 1'b1;
         r.e_addr = t.alu - 32'(off);
         r.e_be   = 4'(((1 << size) - 1) << lane);
         mask     = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (size * 8)) - 32'd1);
         r.e_wdata = (size == 1) ? (t.rd2 & 32'hFF) * 32'h0101_0101 :
                     (size == 2) ? (t.rd2 & 32'hFFFF) * 32'h0001_0001 : t.rd2;
         if (t.we) begin
            r.e_regwe = 1'b0; r.e_wd = t.alu;
         end else begin
            val = (t.rdata >> (lane * 8)) & mask;
            if (t.sext && size < 4 && val[size * 8 - 1]) val = val | ~mask;
            r.e_regwe = t.regwe; r.e_wd = val;
         end
      end
      return r;
   endfunction

   // Called at a negedge with the stage idle; returns at the negedge where valid_o is due.
   task automatic run_txn(input txn_t t, input string tag);
      chk({tag, ".ready_in"}, 32'(ready_o), 32'd1);
      aluout_i = t.alu; rd2_i = t.rd2; memre_i = t.re; memwe_i = t.we; memlen_i = t.len;
      memsext_i = t.sext; regwe_i = t.regwe; wa_i = t.wa; valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      if (t.e_mem) begin
         for (int w = 0; w <= t.waits; w++) begin
            chk({tag, ".req"}, 32'(dm.dm_req_o), 32'd1);
            chk({tag, ".we"}, 32'(dm.dm_we_o), 32'(t.we));
            chk({tag, ".addr"}, dm.dm_addr_o, t.e_addr);
            chk({tag, ".be"}, 32'(dm.dm_be_o), 32'(t.e_be));
            if (t.we) chk({tag, ".wdata"}, dm.dm_wdata_o, t.e_wdata);
            chk({tag, ".ready_wait"}, 32'(ready_o), 32'd0);
            chk({tag, ".valid_wait"}, 32'(valid_o), 32'd0);
            chk({tag, ".fwd_busy"}, 32'(fwd_busy_o), 32'(!t.we));
            chk({tag, ".fwd_we"}, 32'(fwd_we_o), 32'(!t.we && t.regwe));
            chk({tag, ".fwd_wa"}, 32'(fwd_wa_o), 32'(t.wa));
            if (w == t.waits) begin
               dm.dm_ack_i = 1'b1; dm.dm_rdata_i = t.rdata;
            end else begin
               dm.dm_rdata_i = $urandom;
            end
            @(negedge clk);
            dm.dm_ack_i = 1'b0; dm.dm_rdata_i = $urandom;
         end
      end
      chk({tag, ".valid"}, 32'(valid_o), 32'd1);
      chk({tag, ".regwe"}, 32'(regwe_o), 32'(t.e_regwe));
      chk({tag, ".wa"}, 32'(wa_o), 32'(t.wa));
      if (!t.e_exc) chk({tag, ".wd"}, wd_o, t.e_wd);
      chk({tag, ".exc"}, 32'(exc_o), 32'(t.e_exc));
      chk({tag, ".fwd_we_out"}, 32'(fwd_we_o), 32'(t.e_regwe));
      chk({tag, ".req_done"}, 32'(dm.dm_req_o), 32'd0);
      chk({tag, ".ready_done"}, 32'(ready_o), 32'd1);
   endtask

   txn_t tbl[$];
   txn_t rt;

   initial begin
      dm.dm_ack_i = 1'b0;
      dm.dm_rdata_i = '0;

      //     re we len   sx rw wa  alu            rd2            rdata          wt mem rw  wd             addr           be       wdata
      tbl.push_back(mk(0, 0, 2'd0, 0, 1, 5,  32'h0000_1234, 32'h0,         32'h0,         0, 0, 1, 32'h0000_1234, 32'h0,         4'h0,    32'h0));
      tbl.push_back(mk(0, 1, 2'd0, 0, 1, 7,  32'h0000_0103, 32'h0000_00AB, 32'h0,         2, 1, 0, 32'h0000_0103, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB));
      tbl.push_back(mk(1, 0, 2'd1, 1, 1, 9,  32'h0000_0202, 32'h0,         32'h8001_0000, 0, 1, 1, 32'hFFFF_8001, 32'h0000_0200, 4'b1100, 32'h0));
      tbl.push_back(mk(1, 0, 2'd1, 0, 1, 10, 32'h0000_0202, 32'h0,         32'h8001_0000, 0, 1, 1, 32'h0000_8001, 32'h0000_0200, 4'b1100, 32'h0));
      tbl.push_back(mk(1, 0, 2'd2, 0, 1, 12, 32'h0000_0300, 32'h0,         32'hCAFE_F00D, 3, 1, 1, 32'hCAFE_F00D, 32'h0000_0300, 4'b1111, 32'h0));
      tbl.push_back(mk(1, 0, 2'd0, 1, 1, 3,  32'h0000_0101, 32'h0,         32'h0000_8000, 1, 1, 1, 32'hFFFF_FF80, 32'h0000_0100, 4'b0010, 32'h0));
      tbl.push_back(mk(1, 0, 2'd0, 0, 1, 4,  32'h0000_0102, 32'h0,         32'h00AB_0000, 0, 1, 1, 32'h0000_00AB, 32'h0000_0100, 4'b0100, 32'h0));
      tbl.push_back(mk(0, 1, 2'd1, 0, 1, 6,  32'h0000_0106, 32'h1234_CAFE, 32'h0,         0, 1, 0, 32'h0000_0106, 32'h0000_0104, 4'b1100, 32'hCAFE_CAFE));
      tbl.push_back(mk(1, 1, 2'd2, 0, 1, 8,  32'h0000_0400, 32'h0000_55AA, 32'h1111_1111, 1, 1, 0, 32'h0000_0400, 32'h0000_0400, 4'b1111, 32'h0000_55AA));
      tbl.push_back(mk(1, 0, 2'd3, 0, 1, 1,  32'h0000_0500, 32'h0,         32'hDEAD_BEEF, 0, 1, 1, 32'hDEAD_BEEF, 32'h0000_0500, 4'b1111, 32'h0));
      tbl.push_back(mk(0, 0, 2'd0, 0, 0, 31, 32'hFFFF_FFFF, 32'h0,         32'h0,         0, 0, 0, 32'hFFFF_FFFF, 32'h0,         4'h0,    32'h0));

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst.valid", 32'(valid_o), 32'd0);
      chk("rst.req", 32'(dm.dm_req_o), 32'd0);
      chk("rst.regwe", 32'(regwe_o), 32'd0);
      chk("rst.wd", wd_o, 32'd0);
      chk("rst.fwd_we", 32'(fwd_we_o), 32'd0);
      chk("rst.fwd_busy", 32'(fwd_busy_o), 32'd0);
      chk("rst.exc", 32'(exc_o), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst.ready", 32'(ready_o), 32'd1);

      // Directed table, issued back to back
      for (int i = 0; i < tbl.size(); i++) run_txn(tbl[i], $sformatf("tbl%0d", i));
      @(negedge clk);
      chk("pulse.valid", 32'(valid_o), 32'd0);

`ifdef MEM_MISALIGN_EXC_EN
      aluout_i = 32'h201; memre_i = 1'b1; memwe_i = 1'b0; memlen_i = 2'd2; regwe_i = 1'b1;
      wa_i = 5'd11; valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk("exc.req", 32'(dm.dm_req_o), 32'd0);
      chk("exc.valid", 32'(valid_o), 32'd1);
      chk("exc.flag", 32'(exc_o), 32'd1);
      chk("exc.regwe", 32'(regwe_o), 32'd0);
      @(negedge clk);
      chk("exc.pulse", 32'(exc_o), 32'd0);
      chk("exc.req2", 32'(dm.dm_req_o), 32'd0);
`else
      run_txn(mk(1, 0, 2'd2, 0, 1, 11, 32'h201, 32'h0, 32'h1122_3344, 0, 1, 1, 32'h1122_3344,
                 32'h200, 4'b1111, 32'h0), "noexc");
      @(negedge clk);
`endif

      // Randomized transactions against the reference model
      for (int i = 0; i < 60; i++) begin
         int op;
         op = int'($urandom_range(0, 3));
         rt.re = (op == 1 || op == 3); rt.we = (op == 2 || op == 3);
         rt.len = 2'($urandom_range(0, 3)); rt.sext = 1'($urandom); rt.regwe = 1'($urandom);
         rt.wa = 5'($urandom); rt.alu = $urandom; rt.rd2 = $urandom; rt.rdata = $urandom;
         rt.waits = int'($urandom_range(0, 3));
         rt = model(rt);
         run_txn(rt, $sformatf("rnd%0d", i));
      end
      @(negedge clk);

      // Reset while a load is waiting for ack
      aluout_i = 32'h600; memre_i = 1'b1; memwe_i = 1'b0; memlen_i = 2'd2; regwe_i = 1'b1;
      wa_i = 5'd4; valid_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk("abort.req_before", 32'(dm.dm_req_o), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort.req_dropped", 32'(dm.dm_req_o), 32'd0);
      chk("abort.valid", 32'(valid_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      dm.dm_ack_i = 1'b1; dm.dm_rdata_i = 32'h5555_AAAA;
      @(negedge clk);
      dm.dm_ack_i = 1'b0;
      chk("abort.late_ack_valid", 32'(valid_o), 32'd0);
      chk("abort.late_ack_ready", 32'(ready_o), 32'd1);
      @(negedge clk);
      chk("abort.valid_after", 32'(valid_o), 32'd0);
      chk("abort.wd", wd_o, 32'd0);
      chk("abort.fwd_busy", 32'(fwd_busy_o), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Pipeline memory stage of the five-stage CPU. Consumes the execute-stage result bundle (ALU result, store data, memory length/write/read controls, destination register), runs one load or store per instruction against the data memory over a req/ack handshake, and registers the write-back bundle for the writeback stage. It stalls upstream while a memory transaction is outstanding and exposes its pending destination for forwarding/hazard logic.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data width (fixed 32; byte-lane logic assumes 4 lanes)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-low reset
- valid_i  input  1  execute bundle valid this cycle
- ready_o  output  1  stage can accept bundle (low = stall upstream)
- aluout_i  input  32  ALU result; byte address for memory ops
- rd2_i  input  32  store data
- memre_i  input  1  load
- memwe_i  input  1  store
- memlen_i  input  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- memsext_i  input  1  sign-extend load (1) or zero-extend (0)
- regwe_i  input  1  register write enable
- wa_i  input  5  destination register
- dm_req_o  output  1  memory request
- dm_we_o  output  1  request is a store
- dm_addr_o  output  32  word-aligned address ({addr[31:2],2'b00})
- dm_be_o  output  4  byte enables, little-endian
- dm_wdata_o  output  32  lane-replicated store data
- dm_ack_i  input  1  memory completes request (rdata valid same cycle for loads)
- dm_rdata_i  input  32  load word
- valid_o, regwe_o  output  1 each  write-back bundle valid / write enable
- wa_o  output  5  write-back destination
- wd_o  output  32  write-back data (load result for loads, else aluout)
- fwd_we_o  output  1  stage holds an in-flight instruction that will write a register
- fwd_wa_o  output  5  its destination
- fwd_busy_o  output  1  that instruction is a load whose data is not yet available
- exc_o  output  1  misaligned access (only with MEM_MISALIGN_EXC_EN)

## Operation
- States: IDLE, WAIT. Reset → IDLE; all outputs 0 during and after reset; ready_o = 1 in IDLE.
- IDLE, valid_i, no memre/memwe: output registers load {regwe_i, wa_i, aluout_i}; valid_o = 1 next cycle.
- IDLE, valid_i, load or store: capture bundle; next state WAIT; dm_req_o asserted from the next cycle.
- WAIT: ready_o = 0; dm_req_o, dm_we_o, dm_addr_o, dm_be_o, dm_wdata_o held stable until the dm_ack_i cycle. On ack: output registers load (wd_o = aligned load data for loads, aluout for stores; regwe_o = 0 for stores), → IDLE.
- valid_o is a one-cycle pulse per instruction; valid_o = 0 otherwise.
- memre_i and memwe_i both set: treated as store.
- Byte lanes: byte be = 1<<addr[1:0]; half be = addr[1] ? 1100 : 0011; word be = 1111. Store data: byte replicated ×4, half ×2.
- Load extract: lane selected by addr[1:0]/addr[1]; extended to 32 per memsext.
- Forwarding: fwd_we_o/fwd_wa_o reflect the captured instruction while in WAIT and the output register otherwise; fwd_busy_o = 1 in WAIT for loads.
- Reset asserted mid-transaction: FSM → IDLE, request dropped, no valid_o for the aborted instruction; a late dm_ack_i is ignored in IDLE.

## Timing
- Non-memory op: 1-cycle latency (valid_i → valid_o).
- Memory op with ack on first request cycle: accept T, dm_req_o at T+1, valid_o at T+2. Each extra wait cycle adds one.
- Back-to-back: next bundle accepted in the cycle after ack (ready_o = 1 again in IDLE).

## Configuration
- MEM_MISALIGN_EXC_EN defined: half with addr[0]=1 or word with addr[1:0]≠0 → no memory request; exc_o = 1 with valid_o (1 cycle after accept), regwe_o = 0.
- Undefined: low address bits ignored as needed (half uses addr[1], word uses none); exc_o tied 0; access proceeds.

## Structure
- Shared constants header: memlen encodings, state encodings, byte-enable constants.
- One sub-module: load_align (combinational lane select + sign/zero extension), reusable by any future cache read path.

## Test plan
- ALU op, aluout_i=0x1234, wa_i=5, regwe_i=1 → next cycle valid_o=1, wa_o=5, wd_o=0x1234; no dm_req_o.
- Store byte addr 0x103, rd2_i=0xAB, ack after 2 wait cycles → dm_addr_o=0x100, dm_be_o=1000, dm_wdata_o=0xABABABAB held 3 cycles; ready_o=0 throughout; valid_o with regwe_o=0.
- Load half signed addr 0x202, dm_rdata_i=0x8001_0000, immediate ack → wd_o=0xFFFF8001; zero-extended → 0x00008001.
- Load word, 3 wait cycles → fwd_busy_o=1 and fwd_wa_o=wa_i during WAIT; valid_o on cycle after ack.
- rst low during WAIT → dm_req_o=0 immediately, no valid_o; ack after release ignored.
- With MEM_MISALIGN_EXC_EN: load word at 0x201 → no dm_req_o, exc_o=1 and valid_o=1 next cycle, regwe_o=0.
